// File: rtl/periph_rx_buffer_if.sv
// rtl/periph_rx_buffer_if.sv - peripheral write side and packet stream side of the RX buffer
interface periph_rx_buffer_if #(
  parameter int usb_packet_width     = 32,
  parameter int periph_address_width = 3
);
  localparam int P = usb_packet_width - periph_address_width;

  logic [P-1:0]                rx_data;
  logic                        rx_wren;
  logic                        rx_full;
  logic [usb_packet_width-1:0] pkt_data;
  logic                        pkt_valid;
  logic                        pkt_ready;

  modport master (
    output rx_data, rx_wren, pkt_ready,
    input  rx_full, pkt_data, pkt_valid
  );

  modport slave (
    input  rx_data, rx_wren, pkt_ready,
    output rx_full, pkt_data, pkt_valid
  );
endinterface

// File: rtl/periph_rx_buffer.sv
// rtl/periph_rx_buffer.sv - circular FIFO of peripheral payloads, emitted first-word
// fall-through as {PERIPH_ADDR, payload} packets; overflowing writes are counted, not stored.
module periph_rx_buffer #(
  parameter int usb_packet_width     = 32,
  parameter int periph_address_width = 3,
  parameter int PERIPH_ADDR          = 0,
  parameter int DEPTH                = 16,
  localparam int P                   = usb_packet_width - periph_address_width,
  localparam int L                   = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  periph_rx_buffer_if.slave   bus,
  input  logic                flush,
  output logic [L-1:0]        level,
  output logic [15:0]         drop_count,
  output logic                idle
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [periph_address_width-1:0] ADDR_FIELD = periph_address_width'(PERIPH_ADDR);

  logic [P-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full_q;
  logic          wr_acc;
  logic          rd_acc;
  logic          drop;
  logic [L-1:0]  level_nxt;

  // A dropped write never touches the FIFO, so a same-cycle read still lowers level.
  always_comb begin
    wr_acc    = bus.rx_wren && !full_q;
    rd_acc    = (level != '0) && bus.pkt_ready;
    drop      = bus.rx_wren && full_q && !flush;
    level_nxt = level;
    if (wr_acc && !rd_acc) begin
      level_nxt = level + L'(1);
    end else if (rd_acc && !wr_acc) begin
      level_nxt = level - L'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      full_q     <= 1'b0;
      drop_count <= '0;
    end else begin
      if (drop && drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
        full_q <= 1'b0;
      end else begin
        if (wr_acc) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (rd_acc) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        level  <= level_nxt;
        full_q <= (level_nxt == L'(DEPTH));
      end
    end
  end

  // Storage is not reset; level gates whether its contents are ever presented.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush && !rst) begin
      mem[wr_ptr] <= bus.rx_data;
    end
  end

  assign bus.rx_full   = full_q;
  assign bus.pkt_valid = (level != '0);
  assign bus.pkt_data  = {ADDR_FIELD, mem[rd_ptr]};
  assign idle          = (level == '0) && !bus.rx_wren;
endmodule

// File: tb/tb_periph_rx_buffer.sv
// tb/tb_periph_rx_buffer.sv - queue-model bench for periph_rx_buffer with directed and random stimulus
module tb_periph_rx_buffer;
  localparam int W     = 32;
  localparam int AW    = 3;
  localparam int P     = W - AW;
  localparam int DEPTH = 4;
  localparam int ADDR  = 5;
  localparam int L     = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [L-1:0]  level;
  logic [15:0]   drop_count;
  logic          idle;

  periph_rx_buffer_if #(.usb_packet_width(W), .periph_address_width(AW)) bus ();

  periph_rx_buffer #(
    .usb_packet_width(W), .periph_address_width(AW), .PERIPH_ADDR(ADDR), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .flush(flush),
    .level(level), .drop_count(drop_count), .idle(idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [P-1:0] q[$];
  int unsigned  m_drops = 0;
  bit           cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a plain queue updated from the inputs seen at each edge.
  bit m_full;
  bit m_rd;
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_drops = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      m_full = (q.size() == DEPTH);
      m_rd   = (q.size() != 0) && bus.pkt_ready;
      if (bus.rx_wren && m_full && m_drops < 32'hFFFF) m_drops++;
      if (m_rd) void'(q.pop_front());
      if (bus.rx_wren && !m_full) q.push_back(bus.rx_data);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("level", 32'(level), 32'(q.size()));
      check("rx_full", 32'(bus.rx_full), 32'(q.size() == DEPTH));
      check("pkt_valid", 32'(bus.pkt_valid), 32'(q.size() != 0));
      check("drop_count", 32'(drop_count), m_drops);
      check("idle", 32'(idle), 32'(q.size() == 0 && !bus.rx_wren));
      if (q.size() != 0) check("pkt_data", bus.pkt_data, {3'(ADDR), q[0]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wren, input logic [P-1:0] data, input logic ready);
    bus.rx_wren   = wren;
    bus.rx_data   = data;
    bus.pkt_ready = ready;
  endtask

  initial begin
    drive(1'b0, '0, 1'b0);
    tick();
    cmp_en = 1'b1;
    check("rst_level", 32'(level), 0);
    check("rst_rx_full", 32'(bus.rx_full), 0);
    check("rst_pkt_valid", 32'(bus.pkt_valid), 0);
    check("rst_drop", 32'(drop_count), 0);
    check("rst_idle", 32'(idle), 1);
    rst = 1'b0;

    // single word fall-through
    drive(1'b1, 29'h0000123, 1'b1);
    tick();
    drive(1'b0, '0, 1'b1);
    check("ft_valid", 32'(bus.pkt_valid), 1);
    check("ft_data", bus.pkt_data, 32'hA0000123);
    tick();
    check("ft_valid_after", 32'(bus.pkt_valid), 0);
    check("ft_level_after", 32'(level), 0);

    // fill, overflow by two, drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, P'(32'h1000 + i), 1'b0);
      tick();
    end
    check("fill_full", 32'(bus.rx_full), 1);
    check("fill_level", 32'(level), 4);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 29'h0BAD, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b1);
    check("ovf_drop", 32'(drop_count), 2);
    for (int i = 0; i < 4; i++) begin
      check("drain_data", bus.pkt_data, 32'hA0001000 + i);
      tick();
    end
    check("drain_level", 32'(level), 0);

    // overflow concurrent with a read
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, P'(32'h2000 + i), 1'b0);
      tick();
    end
    drive(1'b1, 29'h0DEAD, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    check("rdovf_level", 32'(level), 3);
    check("rdovf_drop", 32'(drop_count), 3);
    check("rdovf_head", bus.pkt_data, 32'hA0002001);

    // flush with a same-cycle write
    flush = 1'b1;
    drive(1'b1, 29'h77, 1'b0);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, 1'b0);
    check("flush_level", 32'(level), 0);
    check("flush_valid", 32'(bus.pkt_valid), 0);
    check("flush_drop", 32'(drop_count), 3);

    // streaming through, pointers wrap
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, P'(32'h3000 + i), 1'b1);
      tick();
      check("stream_level", 32'(level), 1);
      check("stream_data", bus.pkt_data, 32'hA0003000 + i);
    end
    drive(1'b0, '0, 1'b1);
    tick();
    check("stream_end_level", 32'(level), 0);

    // randomized traffic with varying pressure
    for (int blk = 0; blk < 4; blk++) begin
      int wp;
      int rp;
      wp = (blk % 2 == 0) ? 75 : 30;
      rp = (blk % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 500; i++) begin
        drive(($urandom_range(0, 99) < wp), P'($urandom), ($urandom_range(0, 99) < rp));
        flush = ($urandom_range(0, 59) == 0);
        rst   = ($urandom_range(0, 199) == 0);
        tick();
      end
    end
    flush = 1'b0;
    rst   = 1'b1;
    drive(1'b0, '0, 1'b0);
    tick();
    rst = 1'b0;

    // drop counter saturation
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, P'(i), 1'b0);
      tick();
    end
    drive(1'b1, 29'h1, 1'b0);
    for (int i = 0; i < 65534; i++) tick();
    check("sat_fffe", 32'(drop_count), 32'hFFFE);
    for (int i = 0; i < 3; i++) tick();
    check("sat_ffff", 32'(drop_count), 32'hFFFF);

    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    tick();
    check("final_level", 32'(level), 0);
    check("final_rx_full", 32'(bus.rx_full), 0);
    check("final_valid", 32'(bus.pkt_valid), 0);
    check("final_drop", 32'(drop_count), 0);
    check("final_idle", 32'(idle), 1);
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/periph_rx_buffer.md
PERIPH_RX_BUFFER -- requirements
Module: periph_rx_buffer

Interface
REQ-001 SHALL have parameter usb_packet_width, default 32, width of a USB packet word.
REQ-002 SHALL have parameter periph_address_width, default 3, width of the peripheral address field.
REQ-003 SHALL have parameter PERIPH_ADDR, default 0, address this block's peripheral owns.
REQ-004 SHALL have parameter DEPTH, default 16, FIFO entries, power of two, >= 2.
REQ-005 Let P = usb_packet_width-periph_address_width (payload width) and L = log2(DEPTH)+1.
REQ-006 SHALL have one clock and a synchronous, active-high reset; the ports are:
REQ-007 clk  input  1  sole clock, all logic on rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 rx_data  input  P  payload word from the peripheral.
REQ-010 rx_wren  input  1  peripheral write strobe, one word per high cycle.
REQ-011 rx_full  output  1  back-pressure to the peripheral.
REQ-012 flush  input  1  synchronous FIFO clear, active high.
REQ-013 pkt_data  output  usb_packet_width  {PERIPH_ADDR, payload} toward the USB TX arbiter.
REQ-014 pkt_valid  output  1  pkt_data holds a valid packet.
REQ-015 pkt_ready  input  1  arbiter accepts pkt_data this cycle.
REQ-016 level  output  L  current number of stored words.
REQ-017 drop_count  output  16  words lost to overflow, saturating.
REQ-018 idle  output  1  FIFO empty and no write this cycle.

Function
REQ-019 SHALL store words in a circular FIFO of DEPTH entries with write/read pointers wrapping DEPTH-1 -> 0.
REQ-020 Write accepted when rx_wren=1 and rx_full=0; stores rx_data at write pointer, increments pointer.
REQ-021 rx_wren=1 while rx_full=1 SHALL drop the word, leave FIFO unchanged, increment drop_count, even if a read occurs that cycle.
REQ-022 drop_count SHALL saturate at 16'hFFFF, never wrap.
REQ-023 rx_full SHALL be registered-equivalent to (level==DEPTH); pkt_valid SHALL equal (level!=0).
REQ-024 Output is first-word fall-through: pkt_data = {PERIPH_ADDR, mem[read pointer]} whenever pkt_valid=1.
REQ-025 Transfer occurs when pkt_valid=1 and pkt_ready=1; read pointer increments that cycle.
REQ-026 pkt_data and pkt_valid SHALL remain stable while pkt_valid=1 and pkt_ready=0.
REQ-027 pkt_ready while pkt_valid=0 SHALL have no effect.
REQ-028 Write latency: word written at edge N SHALL appear (valid, when FIFO was empty) after edge N, i.e. in cycle N+1; no combinational rx_data -> pkt_data path.
REQ-029 Simultaneous accepted write and transfer SHALL leave level unchanged.
REQ-030 level SHALL update each cycle: +1 write only, -1 read only, 0 both or neither.
REQ-031 flush=1 SHALL zero both pointers and level at the edge, discard any same-cycle write (not counted as drop) and any same-cycle read; drop_count retained.
REQ-032 idle SHALL equal (level==0) and (rx_wren==0).
REQ-033 Payload bits SHALL pass unmodified; address field SHALL be PERIPH_ADDR truncated to periph_address_width.

Reset
REQ-034 rst=1 at an edge SHALL zero pointers, level, drop_count; rx_full=0, pkt_valid=0, idle=1 when rx_wren=0.
REQ-035 rst SHALL take priority over flush, rx_wren and pkt_ready; memory contents need not be cleared.
REQ-036 Reset mid-transfer SHALL discard all stored words; no partial packet emitted after reset.

Verification (DEPTH=4, PERIPH_ADDR=5, usb_packet_width=32, periph_address_width=3)
REQ-037 Empty FIFO, write 29'h0000123 at edge N, pkt_ready=1 -> cycle N+1 pkt_valid=1, pkt_data=32'hA0000123; cycle N+2 pkt_valid=0, level=0.
REQ-038 pkt_ready=0, write 4 words -> rx_full=1, level=4; 2 more writes -> drop_count=2, FIFO contents/order unchanged on drain.
REQ-039 FIFO full, rx_wren=1 and pkt_ready=1 same cycle -> word dropped, drop_count+1, level=3.
REQ-040 Continuous write and pkt_ready=1 for 10 cycles -> 10 packets in order, level stays 1, pointers wrap twice without loss.
REQ-041 level=3, flush=1 with rx_wren=1 -> next cycle level=0, pkt_valid=0, drop_count unchanged.
REQ-042 drop_count forced to 16'hFFFE, 3 dropped writes -> drop_count=16'hFFFF; then rst -> all outputs at reset values.
